// File: rtl/sirv_debug_entry_ctrl_pkg.sv
// Shared dcause codes and FSM state encoding for the debug entry/exit sequencer.
package sirv_debug_entry_ctrl_pkg;

   localparam logic [2:0] DCAUSE_NONE    = 3'd0;
   localparam logic [2:0] DCAUSE_EBREAK  = 3'd1;
   localparam logic [2:0] DCAUSE_HALTREQ = 3'd3;
   localparam logic [2:0] DCAUSE_STEP    = 3'd4;

   typedef enum logic [2:0] {
      ST_RUN   = 3'd0,
      ST_STEP  = 3'd1,
      ST_ENTER = 3'd2,
      ST_DEBUG = 3'd3,
      ST_EXIT  = 3'd4
   } dbg_state_e;

endpackage

// File: rtl/sirv_debug_tmo_cnt.sv
// Halt-request timeout counter: counts while enabled, saturates at all-ones (hit), clears on clr.
module sirv_debug_tmo_cnt #(
   parameter int TMO_W = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic hit
);

   logic [TMO_W-1:0] cnt;

   assign hit = &cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !hit) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sirv_debug_entry_ctrl.sv
// Debug-mode entry/exit sequencer: writes dpc/dcause and requests the flush to debug ROM or back to dpc.
// Optional E203_DBG_HALT_TMO_EN: haltreq waits for a commit, or for the timeout counter to saturate.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_RUN   | normal execution, watching ebreak / haltreq
//  ST_STEP  | single-step window, the next commit re-enters debug
//  ST_ENTER | dpc/dcause written, flush to debug ROM pending ack
//  ST_DEBUG | executing debug ROM, waiting for dret
//  ST_EXIT  | dret seen, flush back to dpc pending ack
module sirv_debug_entry_ctrl
   import sirv_debug_entry_ctrl_pkg::*;
#(
   parameter int PC_SIZE = 32,
   parameter int TMO_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               dbg_irq_r,
   input  logic               dbg_mode,
   input  logic               dbg_step_r,
   input  logic               dbg_ebreakm_r,
   input  logic               cmt_valid,
   input  logic [PC_SIZE-1:0] cmt_pc,
   input  logic [PC_SIZE-1:0] cmt_nxt_pc,
   input  logic               cmt_ebreak,
   input  logic               cmt_dret,
   output logic               cmt_stall,
   output logic [PC_SIZE-1:0] cmt_dpc,
   output logic               cmt_dpc_ena,
   output logic [2:0]         cmt_dcause,
   output logic               cmt_dcause_ena,
   output logic               flush_req,
   input  logic               flush_ack,
   output logic               flush_to_dbg
);

   dbg_state_e         state, nxt_state;
   logic               step_armed, step_armed_nxt;
   logic [PC_SIZE-1:0] held_nxt_pc, dpc_q, dpc_new;
   logic [2:0]         dcause_q, dcause_new;
   logic               dpc_ena_c, dcause_ena_c, flush_c, to_dbg_c;
   logic               in_step, running, ent_ebreak, halt_go, step_go;

   assign in_step    = (state == ST_STEP);
   assign running    = (state == ST_RUN) || in_step;
   assign ent_ebreak = cmt_valid && cmt_ebreak && dbg_ebreakm_r;
   assign step_go    = in_step && cmt_valid;

`ifdef E203_DBG_HALT_TMO_EN
   logic tmo_hit, tmo_inc, tmo_clr;

   assign tmo_inc = (state == ST_RUN) && dbg_irq_r && !cmt_valid;
   assign tmo_clr = (state != ST_RUN) || cmt_valid;

   sirv_debug_tmo_cnt #(.TMO_W(TMO_W)) u_tmo_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (tmo_inc),
      .clr   (tmo_clr),
      .hit   (tmo_hit)
   );

   // In the step window a pending haltreq must not wait: the step would otherwise be lost.
   assign halt_go = dbg_irq_r && (cmt_valid || in_step || tmo_hit);
`else
   // TMO_W only sizes the timeout counter, which this build does not have.
   logic tmo_unused;
   assign tmo_unused = (TMO_W > 0);
   assign halt_go    = dbg_irq_r;
`endif

   always_comb begin
      nxt_state      = state;
      step_armed_nxt = step_armed;
      dpc_ena_c      = 1'b0;
      dcause_ena_c   = 1'b0;
      dpc_new        = dpc_q;
      dcause_new     = dcause_q;
      flush_c        = 1'b0;
      to_dbg_c       = 1'b0;
      case (state)
         ST_RUN, ST_STEP: begin
            if (ent_ebreak || halt_go || step_go) begin
               dpc_ena_c    = 1'b1;
               dcause_ena_c = 1'b1;
               flush_c      = 1'b1;
               to_dbg_c     = 1'b1;
               nxt_state    = flush_ack ? ST_DEBUG : ST_ENTER;
               if (ent_ebreak) begin
                  dpc_new    = cmt_pc;
                  dcause_new = DCAUSE_EBREAK;
               end else if (halt_go) begin
                  dpc_new    = cmt_valid ? cmt_nxt_pc : held_nxt_pc;
                  dcause_new = DCAUSE_HALTREQ;
               end else begin
                  dpc_new    = cmt_nxt_pc;
                  dcause_new = DCAUSE_STEP;
               end
            end
         end
         ST_ENTER: begin
            flush_c  = 1'b1;
            to_dbg_c = 1'b1;
            if (flush_ack) nxt_state = ST_DEBUG;
         end
         ST_DEBUG: begin
            if (cmt_valid && cmt_dret && dbg_mode) begin
               dcause_ena_c   = 1'b1;
               dcause_new     = DCAUSE_NONE;
               flush_c        = 1'b1;
               step_armed_nxt = dbg_step_r;
               if (flush_ack) nxt_state = dbg_step_r ? ST_STEP : ST_RUN;
               else           nxt_state = ST_EXIT;
            end
         end
         ST_EXIT: begin
            flush_c = 1'b1;
            if (flush_ack) nxt_state = step_armed ? ST_STEP : ST_RUN;
         end
         default: nxt_state = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_RUN;
         step_armed  <= 1'b0;
         held_nxt_pc <= '0;
         dpc_q       <= '0;
         dcause_q    <= DCAUSE_NONE;
      end else begin
         state      <= nxt_state;
         step_armed <= step_armed_nxt;
         if (running && cmt_valid) held_nxt_pc <= cmt_nxt_pc;
         if (dpc_ena_c)            dpc_q       <= dpc_new;
         if (dcause_ena_c)         dcause_q    <= dcause_new;
      end
   end

   // Decisions are combinational on the commit inputs; gating with rst_n drops them the moment reset asserts.
   assign cmt_dpc_ena    = rst_n && dpc_ena_c;
   assign cmt_dcause_ena = rst_n && dcause_ena_c;
   assign flush_req      = rst_n && flush_c;
   assign flush_to_dbg   = rst_n && to_dbg_c;
   assign cmt_stall      = flush_req;
   assign cmt_dpc        = cmt_dpc_ena ? dpc_new : dpc_q;
   assign cmt_dcause     = cmt_dcause_ena ? dcause_new : dcause_q;

endmodule

// File: tb/tb_sirv_debug_entry_ctrl.sv
// Self-checking bench for sirv_debug_entry_ctrl: directed scenarios plus a cycle-by-cycle behavioural model.
module tb_sirv_debug_entry_ctrl;

   localparam int PC_SIZE = 32;
   localparam int TMO_W   = 4;
   localparam int TMO_MAX = (1 << TMO_W) - 1;

   logic               clk, rst_n;
   logic               dbg_irq_r, dbg_mode, dbg_step_r, dbg_ebreakm_r;
   logic               cmt_valid, cmt_ebreak, cmt_dret, flush_ack;
   logic [PC_SIZE-1:0] cmt_pc, cmt_nxt_pc, cmt_dpc;
   logic               cmt_stall, cmt_dpc_ena, cmt_dcause_ena, flush_req, flush_to_dbg;
   logic [2:0]         cmt_dcause;

   int checks = 0;
   int errors = 0;

   sirv_debug_entry_ctrl #(.PC_SIZE(PC_SIZE), .TMO_W(TMO_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .dbg_irq_r      (dbg_irq_r),
      .dbg_mode       (dbg_mode),
      .dbg_step_r     (dbg_step_r),
      .dbg_ebreakm_r  (dbg_ebreakm_r),
      .cmt_valid      (cmt_valid),
      .cmt_pc         (cmt_pc),
      .cmt_nxt_pc     (cmt_nxt_pc),
      .cmt_ebreak     (cmt_ebreak),
      .cmt_dret       (cmt_dret),
      .cmt_stall      (cmt_stall),
      .cmt_dpc        (cmt_dpc),
      .cmt_dpc_ena    (cmt_dpc_ena),
      .cmt_dcause     (cmt_dcause),
      .cmt_dcause_ena (cmt_dcause_ena),
      .flush_req      (flush_req),
      .flush_ack      (flush_ack),
      .flush_to_dbg   (flush_to_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model view: debug flag, pending flush kind (0 none, 1 to ROM, 2 to dpc), step window, last PCs written.
   logic        m_dbg, m_step, m_arm;
   int          m_fl, m_tmo;
   logic [31:0] m_held, m_dpc;
   logic [2:0]  m_cause;

   always @(negedge clk) begin : model
      logic        e_dpc_ena, e_cause_ena, e_flush, e_todbg, halt_ok;
      logic [31:0] e_dpc;
      logic [2:0]  e_cause;
      int          cause;
      if (!rst_n) begin
         m_dbg = 0; m_step = 0; m_arm = 0; m_fl = 0; m_tmo = 0;
         m_held = 0; m_dpc = 0; m_cause = 0;
         check("rst_dpc_ena", 32'(cmt_dpc_ena), 0);
         check("rst_dcause_ena", 32'(cmt_dcause_ena), 0);
         check("rst_flush_req", 32'(flush_req), 0);
         check("rst_stall", 32'(cmt_stall), 0);
         check("rst_dpc", cmt_dpc, 0);
         check("rst_dcause", 32'(cmt_dcause), 0);
      end else begin
         e_dpc_ena = 0; e_cause_ena = 0; e_flush = 0; e_todbg = 0;
         e_dpc = m_dpc; e_cause = m_cause; cause = 0;
         if (m_fl != 0) begin
            e_flush = 1;
            e_todbg = (m_fl == 1);
            if (flush_ack) begin
               if (m_fl == 1) m_dbg = 1;
               else           m_step = m_arm;
               m_fl = 0;
            end
         end else if (m_dbg) begin
            if (cmt_valid && cmt_dret && dbg_mode) begin
               e_cause_ena = 1; e_cause = 0; e_flush = 1;
               m_arm = dbg_step_r; m_dbg = 0;
               if (flush_ack) m_step = dbg_step_r;
               else           m_fl = 2;
            end
         end else begin
`ifdef E203_DBG_HALT_TMO_EN
            halt_ok = dbg_irq_r && (cmt_valid || m_step || m_tmo == TMO_MAX);
`else
            halt_ok = dbg_irq_r;
`endif
            if (cmt_valid && cmt_ebreak && dbg_ebreakm_r) begin
               cause = 1; e_dpc = cmt_pc;
            end else if (halt_ok) begin
               cause = 3; e_dpc = cmt_valid ? cmt_nxt_pc : m_held;
            end else if (m_step && cmt_valid) begin
               cause = 4; e_dpc = cmt_nxt_pc;
            end
            if (cause != 0 || m_step || cmt_valid) m_tmo = 0;
            else if (dbg_irq_r && m_tmo < TMO_MAX) m_tmo++;
            if (cmt_valid) m_held = cmt_nxt_pc;
            if (cause != 0) begin
               e_dpc_ena = 1; e_cause_ena = 1; e_cause = 3'(cause);
               e_flush = 1; e_todbg = 1; m_step = 0;
               if (flush_ack) m_dbg = 1;
               else           m_fl = 1;
            end
         end
         check("m_dpc_ena", 32'(cmt_dpc_ena), 32'(e_dpc_ena));
         check("m_dcause_ena", 32'(cmt_dcause_ena), 32'(e_cause_ena));
         check("m_flush_req", 32'(flush_req), 32'(e_flush));
         check("m_stall", 32'(cmt_stall), 32'(e_flush));
         if (e_flush) check("m_flush_to_dbg", 32'(flush_to_dbg), 32'(e_todbg));
         check("m_dpc", cmt_dpc, e_dpc);
         check("m_dcause", 32'(cmt_dcause), 32'(e_cause));
         if (e_dpc_ena)   m_dpc = e_dpc;
         if (e_cause_ena) m_cause = e_cause;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic at_mid();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      cmt_valid = 0; cmt_ebreak = 0; cmt_dret = 0; flush_ack = 0;
   endtask

   // Called in DEBUG; returns one cycle after the exit flush is acknowledged.
   task automatic do_dret(input logic step, input string tag);
      cmt_valid = 1; cmt_dret = 1; dbg_step_r = step;
      cmt_pc = 32'h0000_0800; cmt_nxt_pc = 32'h0000_0804;
      at_mid();
      check({tag, "_dret_dcause_ena"}, 32'(cmt_dcause_ena), 1);
      check({tag, "_dret_dcause"}, 32'(cmt_dcause), 0);
      check({tag, "_dret_dpc_ena"}, 32'(cmt_dpc_ena), 0);
      check({tag, "_dret_to_dbg"}, 32'(flush_to_dbg), 0);
      cyc(); idle(); dbg_mode = 0;
      cyc(); flush_ack = 1;
      cyc(); flush_ack = 0;
   endtask

   initial begin
      rst_n = 0; dbg_irq_r = 0; dbg_mode = 0; dbg_step_r = 0; dbg_ebreakm_r = 0;
      cmt_pc = 0; cmt_nxt_pc = 0;
      idle();
      repeat (3) cyc();
      check("reset_flush_req", 32'(flush_req), 0);
      rst_n = 1;

      // Stray ack with no flush pending.
      cyc(); flush_ack = 1;
      at_mid(); check("stray_ack_flush", 32'(flush_req), 0);
      cyc(); flush_ack = 0;

      // 1: ebreak with ebreakm.
      dbg_ebreakm_r = 1; cmt_valid = 1; cmt_ebreak = 1;
      cmt_pc = 32'h8000_0100; cmt_nxt_pc = 32'h8000_0104;
      at_mid();
      check("t1_dpc_ena", 32'(cmt_dpc_ena), 1);
      check("t1_dcause_ena", 32'(cmt_dcause_ena), 1);
      check("t1_dpc", cmt_dpc, 32'h8000_0100);
      check("t1_dcause", 32'(cmt_dcause), 1);
      check("t1_flush_req", 32'(flush_req), 1);
      check("t1_to_dbg", 32'(flush_to_dbg), 1);
      cyc(); idle();
      at_mid();
      check("t1_enter_no_strobe", 32'(cmt_dpc_ena), 0);
      check("t1_enter_stall", 32'(cmt_stall), 1);
      cyc(); cyc(); flush_ack = 1;
      cyc(); flush_ack = 0; dbg_mode = 1;
      at_mid();
      check("t1_debug_flush", 32'(flush_req), 0);
      check("t1_debug_dcause_hold", 32'(cmt_dcause), 1);
      cyc(); cmt_valid = 1; cmt_ebreak = 1; cmt_pc = 32'h0000_0810;
      at_mid();
      check("t1_debug_ebreak_no_rewrite", 32'(cmt_dpc_ena), 0);
      check("t1_debug_dpc_hold", cmt_dpc, 32'h8000_0100);
      cyc(); idle();
      do_dret(0, "t1");

      // 2: haltreq with a commit, ack after three flush cycles.
      cmt_valid = 1; cmt_pc = 32'h200; cmt_nxt_pc = 32'h204; dbg_irq_r = 1;
      at_mid();
      check("t2_dcause", 32'(cmt_dcause), 3);
      check("t2_dpc", cmt_dpc, 32'h204);
      cyc(); idle(); dbg_irq_r = 0;
      cyc();
      cyc(); flush_ack = 1;
      at_mid(); check("t2_flush_before_ack", 32'(flush_req), 1);
      cyc(); flush_ack = 0; dbg_mode = 1;
      at_mid();
      check("t2_debug_flush", 32'(flush_req), 0);
      check("t2_debug_stall", 32'(cmt_stall), 0);
      cyc();
      do_dret(1, "t3");

      // 3: single step after dret with step set.
      dbg_step_r = 0;
      at_mid();
      check("t3_step_idle_flush", 32'(flush_req), 0);
      check("t3_step_idle_stall", 32'(cmt_stall), 0);
      cyc(); cmt_valid = 1; cmt_pc = 32'h304; cmt_nxt_pc = 32'h308;
      at_mid();
      check("t3_dpc_ena", 32'(cmt_dpc_ena), 1);
      check("t3_dcause", 32'(cmt_dcause), 4);
      check("t3_dpc", cmt_dpc, 32'h308);
      cyc(); idle();
      cyc(); flush_ack = 1;
      cyc(); flush_ack = 0; dbg_mode = 1;
      cyc();
      do_dret(0, "t3b");

      // 4: ebreak and haltreq together.
      cmt_valid = 1; cmt_ebreak = 1; dbg_irq_r = 1; cmt_pc = 32'h400; cmt_nxt_pc = 32'h404;
      at_mid();
      check("t4_dcause", 32'(cmt_dcause), 1);
      check("t4_dpc", cmt_dpc, 32'h400);
      cyc(); cmt_valid = 0; cmt_ebreak = 0;
      at_mid();
      check("t4_single_dpc_ena", 32'(cmt_dpc_ena), 0);
      check("t4_single_dcause_ena", 32'(cmt_dcause_ena), 0);
      check("t4_dcause_hold", 32'(cmt_dcause), 1);
      cyc(); dbg_irq_r = 0; flush_ack = 1;
      cyc(); flush_ack = 0; dbg_mode = 1;
      cyc();
      do_dret(0, "t4");

      // 5: reset while the entry flush is pending.
      cmt_valid = 1; cmt_ebreak = 1; cmt_pc = 32'h600; cmt_nxt_pc = 32'h604;
      at_mid(); check("t5_dpc", cmt_dpc, 32'h600);
      cyc(); idle();
      at_mid(); check("t5_enter_flush", 32'(flush_req), 1);
      cyc(); rst_n = 0;
      #1;
      check("t5_rst_flush_now", 32'(flush_req), 0);
      check("t5_rst_stall_now", 32'(cmt_stall), 0);
      cyc(); cyc(); rst_n = 1;
      at_mid();
      check("t5_post_dpc_ena", 32'(cmt_dpc_ena), 0);
      check("t5_post_flush", 32'(flush_req), 0);
      check("t5_post_dcause", 32'(cmt_dcause), 0);

      // 6: haltreq without a commit uses the last committed next-PC.
      cyc(); cmt_valid = 1; cmt_pc = 32'h4fc; cmt_nxt_pc = 32'h500;
      cyc(); idle(); dbg_irq_r = 1;
`ifdef E203_DBG_HALT_TMO_EN
      begin : tmo_wait
         int n;
         bit seen;
         seen = 0;
         n = 0;
         for (int i = 1; i <= 40 && !seen; i++) begin
            at_mid();
            if (cmt_dcause_ena) begin
               seen = 1;
               n = i;
            end else begin
               cyc();
            end
         end
         check("t6_tmo_entry_seen", 32'(seen), 1);
         check("t6_tmo_cycle", 32'(n), 16);
      end
`else
      at_mid();
`endif
      check("t6_dcause", 32'(cmt_dcause), 3);
      check("t6_dpc", cmt_dpc, 32'h500);
      cyc(); dbg_irq_r = 0;
      repeat (2) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
